// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings used by the ALU, multiplier and divider,
// the divider state type and the datapath width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic [1:0] MDU_OP_NONE     = 2'b00;
  localparam logic [1:0] MDU_OP_UNSIGNED = 2'b01;
  localparam logic [1:0] MDU_OP_SIGNED   = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

endpackage

// File: rtl/mdu_seq_divider_if.sv
// ALU <-> MDU op/done interface: the ALU (master) issues a one-cycle op with
// operands; the divider (slave) drops done while busy and raises it at commit.
interface mdu_seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]         div_op;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [2*WIDTH-1:0] result;
  logic               done;

  modport master (
    output div_op, dividend, divisor,
    input  result, done
  );

  modport slave (
    input  div_op, dividend, divisor,
    output result, done
  );
endinterface

// File: rtl/mdu_seq_divider_div_iter_step.sv
// One radix-2 restoring division step, kept separate so a radix-4 step can
// be dropped in without touching the control logic.
module div_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] trial;

  // Shift the next dividend bit into the remainder and try to subtract the divisor.
  // rem < divisor holds between steps, so a WIDTH+1-bit difference never overflows
  // and its MSB is the borrow.
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_seq_divider.sv
// Sequential MIPS DIV/DIVU: sign-strip on accept, 32 restoring steps,
// then sign fix-up and commit to result with done rising.
module mdu_seq_divider
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  mdu_seq_divider_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               is_signed;
  logic               start;
  logic [WIDTH-1:0]   rem_step, quo_step;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Next-state logic: accept in IDLE, iterate in CALC, sign-correct and commit in FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    is_signed = (bus.div_op == MDU_OP_SIGNED);
    start     = is_signed || (bus.div_op == MDU_OP_UNSIGNED);
    case (state_q)
      IDLE: begin
        if (start) begin
          // Magnitudes are taken as unsigned, so |0x8000_0000| is simply 2^31.
          quo_d   = (is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
          dvs_d   = (is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
          q_neg_d = is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1])
                    && (bus.divisor != '0);
          r_neg_d = is_signed && bus.dividend[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = {(r_neg_q ? -rem_q : rem_q), (q_neg_q ? -quo_q : quo_q)};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = (state_q == IDLE);

endmodule
